romix_feeder: RTL and testbench
===============================

Name: romix_feeder

Overview:
- Upstream/downstream adapter for the scrypt ROMix core.
- Deserialises a WORD_W-bit stream from the PBKDF2-SHA256 front stage into the 1024-bit ROMix input block, then pulses the ROMix start.
- Captures the 1024-bit ROMix result and re-serialises it, with ready/valid handshake, to the final PBKDF2 stage.
- One block in flight at a time.

Parameters:
- WORD_W, 32, stream word width; legal values 32 or 64; must divide 1024.
- NUM_WORDS, 1024/WORD_W, derived local value (32 at default); not overridable.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- s_valid  in  1  input word valid
- s_data  in  WORD_W  input word
- s_ready  out  1  feeder accepts input word
- romix_init  out  1  one-cycle start pulse to ROMix
- romix_in  out  1024  assembled block to ROMix
- romix_out  in  1024  ROMix result
- romix_valid  in  1  ROMix result valid (level or pulse)
- m_valid  out  1  output word valid
- m_data  out  WORD_W  output word
- m_last  out  1  marks final output word of a block
- m_ready  in  1  downstream accepts output word
- busy  out  1  high in any state other than S_LOAD, or in S_LOAD with word count nonzero

Behaviour:
- Reset: a clk edge with reset_n=0 forces state S_LOAD, word counter 0, in/out buffers 0.
  - While reset_n=0, s_ready, m_valid, m_last, romix_init and busy are all forced to 0 combinationally.
  - romix_in and m_data read 0 after the reset edge.
- Word order: the first accepted word lands in romix_in[WORD_W-1:0]; word k lands in [k*WORD_W +: WORD_W]. Output word k = romix_out[k*WORD_W +: WORD_W], emitted from word 0 upward.
- FSM states:
  - S_LOAD
    - s_ready=1.
    - On s_valid&s_ready, write the word at the counter index and increment the counter.
    - Accepting word NUM_WORDS-1 clears the counter and moves to S_START.
    - Idle cycles with s_valid=0 leave state and counter unchanged.
  - S_START
    - romix_init=1 for exactly this one cycle, then S_WAIT.
  - S_WAIT
    - romix_init=0. romix_in is held stable from S_START until capture.
    - On the first cycle with romix_valid=1, latch romix_out into the output buffer and go to S_DRAIN.
  - S_DRAIN
    - m_valid=1; m_data is the buffer word at the counter index.
    - m_last=1 when the counter equals NUM_WORDS-1.
    - On m_valid&m_ready, increment the counter. The final handshake clears the counter and returns to S_LOAD.
- Latency:
  - romix_init is high in the cycle after the last input handshake.
  - m_valid with word 0 is high in the cycle after romix_valid is sampled in S_WAIT.
  - Minimum drain time is NUM_WORDS cycles with m_ready held at 1.
- Handshake rules:
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake, except on reset.
  - s_ready=0 in S_START, S_WAIT and S_DRAIN; s_data is ignored there.
- Boundary conditions:
  - romix_valid is ignored outside S_WAIT, including when it is already high in S_START.
  - romix_valid held high across many cycles captures only once.
  - m_ready=1 with m_valid=0 has no effect.
- Reset mid-operation: the in-flight block is discarded, with no partial output. Any later romix_valid is ignored until the next S_WAIT.

Optional Feature:
- Macro ROMIX_FEEDER_BSWAP_EN.
- When defined:
  - Each input word is byte-reversed before it is written into romix_in.
  - Each output word is byte-reversed before it drives m_data.
  - This converts the big-endian SHA stream to scrypt little-endian words.
- When undefined: words pass through unmodified.
- Timing and handshakes are identical in both builds.

Test Plan:
- Load 32 words 0x00000000..0x0000001F back-to-back -> romix_in[31:0]=0x00000000, romix_in[1023:992]=0x0000001F; romix_init high for exactly 1 cycle, in the cycle after the 32nd accept; s_ready=0 afterwards.
- ROMix stub returns romix_in XOR {32{0xA5A5A5A5}} 10 cycles after init, with m_ready=1 -> m_data sequence 0xA5A5A5A5..0xA5A5A5BA; m_last only on 0xA5A5A5BA; s_ready=1 the cycle after the last handshake.
- Random m_ready stalls (50%) during drain -> m_data/m_last stable while stalled; exactly 32 distinct words, in order, with no duplicates.
- s_valid gaps during load, and s_valid=1 with data 0xDEADBEEF during S_WAIT/S_DRAIN -> gaps do not advance the counter; 0xDEADBEEF never appears in romix_in.
- reset_n low for 1 cycle while in S_WAIT, then stub asserts romix_valid -> m_valid stays 0; s_ready=1 the cycle after reset deasserts; the next block of 32 words processes correctly.
- With ROMIX_FEEDER_BSWAP_EN defined, first input word 0x11223344 -> romix_in[31:0]=0x44332211; a stub result word 0 of 0xAABBCCDD -> m_data=0xDDCCBBAA.

Source files
------------

// File: rtl/romix_feeder.sv
// Stream adapter around the scrypt ROMix core: gathers NUM_WORDS input words into one
// 1024-bit block, starts ROMix, then replays the result as a ready/valid word stream.
// Build option: define ROMIX_FEEDER_BSWAP_EN to byte-reverse every word in both directions.
module romix_feeder #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              romix_init,
    output logic [1023:0]     romix_in,
    input  logic [1023:0]     romix_out,
    input  logic              romix_valid,
    output logic              m_valid,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
);

    localparam int NUM_WORDS = 1024 / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    // Handshake: a word moves on a rising clk edge where valid and ready are both high;
    // a source holds valid and data stable until that edge, and ready never waits on valid.
    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1023:0]    in_q, in_d;
    logic [1023:0]    out_q, out_d;
    logic             s_ready_c, init_c, m_valid_c;

    function automatic logic [WORD_W-1:0] swap_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
`ifdef ROMIX_FEEDER_BSWAP_EN
        // SHA words arrive big-endian; scrypt works on little-endian words.
        for (int b = 0; b < WORD_W / 8; b++) begin
            r[b*8 +: 8] = w[(WORD_W/8 - 1 - b)*8 +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_d      = in_q;
        out_d     = out_q;
        s_ready_c = 1'b0;
        init_c    = 1'b0;
        m_valid_c = 1'b0;
        case (state_q)
            S_LOAD: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    in_d[cnt_q*WORD_W +: WORD_W] = swap_word(s_data);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                init_c  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only this state listens to romix_valid, so a level held high captures once.
                if (romix_valid) begin
                    out_d   = romix_out;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                m_valid_c = 1'b1;
                if (m_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Control outputs are masked while reset is asserted, independent of the clock.
    assign s_ready    = reset_n & s_ready_c;
    assign romix_init = reset_n & init_c;
    assign m_valid    = reset_n & m_valid_c;
    assign m_last     = reset_n & m_valid_c & (cnt_q == LAST_IDX);
    assign busy       = reset_n & ((state_q != S_LOAD) | (cnt_q != '0));
    assign romix_in   = in_q;
    assign m_data     = swap_word(out_q[cnt_q*WORD_W +: WORD_W]);

endmodule

// File: tb/tb_romix_feeder.sv
// Self-checking bench for romix_feeder: table of block scenarios, random blocks,
// reset-in-flight and word byte-order checks against a word-level reference model.
module tb_romix_feeder;

    localparam int W = 32;
    localparam int N = 1024 / W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          s_ready;
    logic          romix_init;
    logic [1023:0] romix_in;
    logic [1023:0] romix_out;
    logic          romix_valid;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;

    always #5 clk = ~clk;

    romix_feeder #(.WORD_W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .romix_init  (romix_init),
        .romix_in    (romix_in),
        .romix_out   (romix_out),
        .romix_valid (romix_valid),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  blk_in[N];
    logic [W-1:0]  blk_res[N];
    logic [1023:0] snap_in;
    logic [W-1:0]  first_seen, last_seen;
    int            drain_cyc;

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] mask;
        int           gap_pct;
        int           stall_pct;
        int           lat;
        bit           junk;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_last;
    } row_t;

    row_t rows[4];

    // Reference word transform: byte reversal only in the byte-swap build.
    function automatic logic [W-1:0] bsw(input logic [W-1:0] w);
`ifdef ROMIX_FEEDER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [1023:0] model_block();
        logic [1023:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = bsw(blk_in[k]);
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one block from S_LOAD (idle, at a negedge) back to S_LOAD. The ROMix stub
    // returns blk_res[] 'lat' cycles into the wait phase.
    task automatic run_block(input int gap_pct, input int stall_pct, input int lat, input bit junk);
        int            k, cyc;
        logic          acc, pv, pl;
        logic [W-1:0]  pd;
        logic [1023:0] exp_in, res;
        exp_in = model_block();
        for (int i = 0; i < N; i++) res[i*W +: W] = blk_res[i];
        k = 0;
        cyc = 0;
        while (k < N && cyc < 2000) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 32'hDEADBEEF;
            end else begin
                s_valid = 1'b1;
                s_data  = blk_in[k];
            end
            m_ready = 1'($urandom_range(0, 1));
            if (cyc == 0) chk1("s_ready_load", s_ready, 1'b1);
            acc = s_valid & s_ready;
            @(negedge clk);
            if (acc) k++;
            cyc++;
        end
        if (k < N) chk32("load_timeout", W'(k), W'(N));
        s_valid = junk;
        s_data  = 32'hDEADBEEF;
        m_ready = 1'b0;
        if (junk) begin
            romix_valid = 1'b1;
            romix_out   = {32{32'h0BAD0BAD}};
        end
        snap_in = romix_in;
        chk1("init_pulse", romix_init, 1'b1);
        chk1("s_ready_start", s_ready, 1'b0);
        chk1("busy_start", busy, 1'b1);
        chkw("romix_in_load", romix_in, exp_in);
        @(negedge clk);
        romix_valid = 1'b0;
        chk1("init_one_cycle", romix_init, 1'b0);
        for (int i = 0; i < lat; i++) begin
            chk1("m_valid_wait", m_valid, 1'b0);
            @(negedge clk);
        end
        romix_out   = res;
        romix_valid = 1'b1;
        for (int i = 0; i < N; i++) exp_q.push_back(bsw(blk_res[i]));
        @(negedge clk);
        chk1("m_valid_latency", m_valid, 1'b1);
        chkw("romix_in_hold", romix_in, exp_in);
        chk1("s_ready_drain", s_ready, 1'b0);
        romix_out = {32{32'h0BAD0BAD}};
        cyc = 0;
        pv = 1'b0;
        pd = '0;
        pl = 1'b0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (cyc == 3) romix_valid = 1'b0;
            chk1("m_valid_drain", m_valid, 1'b1);
            chk32("m_data", m_data, exp_q[0]);
            chk1("m_last", m_last, exp_q.size() == 1);
            if (pv) begin
                chk32("m_data_stall", m_data, pd);
                chk1("m_last_stall", m_last, pl);
            end
            m_ready = ($urandom_range(0, 99) >= stall_pct);
            pv = ~m_ready;
            pd = m_data;
            pl = m_last;
            if (m_ready) begin
                if (exp_q.size() == N) first_seen = m_data;
                if (exp_q.size() == 1) last_seen = m_data;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        drain_cyc = cyc;
        if (exp_q.size() > 0) begin
            chk32("drain_timeout", W'(exp_q.size()), '0);
            exp_q.delete();
        end
        s_valid     = 1'b0;
        m_ready     = 1'b0;
        romix_valid = 1'b0;
        chk1("m_valid_done", m_valid, 1'b0);
        chk1("s_ready_done", s_ready, 1'b1);
        chk1("busy_done", busy, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        romix_out   = '0;
        romix_valid = 1'b0;
        m_ready     = 1'b0;
        first_seen  = '0;
        last_seen   = '0;
        drain_cyc   = 0;
        snap_in     = '0;

        rows[0] = '{32'h00000000, 32'hA5A5A5A5, 0,  0,  10, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5BA};
        rows[1] = '{32'h00001000, 32'h00000000, 30, 50, 3,  1'b1, 32'h00001000, 32'h0000101F};
        rows[2] = '{32'hFFFFFFF0, 32'h3C3C3C3C, 0,  50, 1,  1'b1, 32'hC3C3C3CC, 32'h3C3C3C33};
        rows[3] = '{32'h80000000, 32'hFFFFFFFF, 50, 20, 0,  1'b0, 32'h7FFFFFFF, 32'h7FFFFFE0};

        // Reset: outputs masked while low, cleared state once released.
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b0;
        #1;
        chk1("post_rst_s_ready", s_ready, 1'b1);
        chk1("post_rst_m_valid", m_valid, 1'b0);
        chk1("post_rst_m_last", m_last, 1'b0);
        chk1("post_rst_init", romix_init, 1'b0);
        chk1("post_rst_busy", busy, 1'b0);
        chkw("post_rst_romix_in", romix_in, '0);
        chk32("post_rst_m_data", m_data, '0);

        foreach (rows[r]) begin
            for (int k = 0; k < N; k++) begin
                blk_in[k]  = rows[r].base + W'(k);
                blk_res[k] = bsw(blk_in[k]) ^ rows[r].mask;
            end
            run_block(rows[r].gap_pct, rows[r].stall_pct, rows[r].lat, rows[r].junk);
            chk32("row_first_word", first_seen, rows[r].exp_first);
            chk32("row_last_word", last_seen, rows[r].exp_last);
            if (r == 0) begin
                chk32("row0_in_word0", snap_in[31:0], bsw(32'h00000000));
                chk32("row0_in_word31", snap_in[1023:992], bsw(32'h0000001F));
                chk32("row0_drain_cycles", W'(drain_cyc), W'(N));
            end
        end

        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < N; k++) begin
                blk_in[k]  = $urandom;
                blk_res[k] = $urandom;
            end
            run_block($urandom_range(0, 60), $urandom_range(0, 80), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting on ROMix: late romix_valid must not produce output.
        for (int k = 0; k < N; k++) begin
            blk_in[k] = $urandom;
            s_valid   = 1'b1;
            s_data    = blk_in[k];
            @(negedge clk);
        end
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_s_ready", s_ready, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n     = 1'b1;
        romix_valid = 1'b1;
        romix_out   = {32{32'h12345678}};
        m_ready     = 1'b1;
        #1;
        chk1("mid_rst_s_ready_after", s_ready, 1'b1);
        chkw("mid_rst_romix_in", romix_in, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("mid_rst_no_output", m_valid, 1'b0);
            chk1("mid_rst_idle", busy, 1'b0);
        end
        romix_valid = 1'b0;
        m_ready     = 1'b0;
        for (int k = 0; k < N; k++) begin
            blk_in[k]  = $urandom;
            blk_res[k] = $urandom;
        end
        run_block(20, 30, 5, 1'b0);

        // Byte order of the first word in each direction.
        for (int k = 0; k < N; k++) begin
            blk_in[k]  = (k == 0) ? 32'h11223344 : $urandom;
            blk_res[k] = (k == 0) ? 32'hAABBCCDD : $urandom;
        end
        run_block(0, 0, 2, 1'b0);
`ifdef ROMIX_FEEDER_BSWAP_EN
        chk32("order_in_word0", snap_in[31:0], 32'h44332211);
        chk32("order_out_word0", first_seen, 32'hDDCCBBAA);
`else
        chk32("order_in_word0", snap_in[31:0], 32'h11223344);
        chk32("order_out_word0", first_seen, 32'hAABBCCDD);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
